// File: rtl/layer_sequencer.sv
// layer_sequencer: walks one shared neuron MAC across a dense layer,
// capturing each activation and tracking the running argmax.
module layer_sequencer #(
   parameter int NUM_NEURONS = 10,
   parameter int INPUT_SIZE  = 784,
   parameter int TIMEOUT     = INPUT_SIZE + 8,
   parameter int SEL_W       = $clog2(NUM_NEURONS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         layer_start,
   output logic                         layer_busy,
   output logic                         layer_done,
   output logic                         timeout_err,
   output logic                         neuron_start,
   output logic [SEL_W-1:0]             neuron_sel,
   input  logic                         neuron_done,
   input  logic signed [15:0]           neuron_result,
   output logic [NUM_NEURONS-1:0][15:0] act_out,
   output logic [SEL_W-1:0]             argmax_idx,
   output logic signed [15:0]           argmax_val
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_NEURONS - 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      DONE
   } state_t;

   state_t          state;
   logic [WD_W-1:0] wdog;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wdog         <= '0;
         layer_busy   <= 1'b0;
         layer_done   <= 1'b0;
         timeout_err  <= 1'b0;
         neuron_start <= 1'b0;
         neuron_sel   <= '0;
         act_out      <= '0;
         argmax_idx   <= '0;
         argmax_val   <= '0;
      end else begin
         neuron_start <= 1'b0;
         layer_done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (layer_start) begin
                  state        <= ISSUE;
                  neuron_sel   <= '0;
                  timeout_err  <= 1'b0;
                  wdog         <= '0;
                  neuron_start <= 1'b1;
                  layer_busy   <= 1'b1;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // done wins over an expiring watchdog in the same cycle
               if (neuron_done) begin
                  state <= CAPTURE;
               end else if (wdog == WD_LAST) begin
                  timeout_err <= 1'b1;
                  layer_done  <= 1'b1;
                  state       <= DONE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            CAPTURE: begin
               act_out[neuron_sel] <= neuron_result;
               wdog                <= '0;
               if (neuron_sel == '0 || neuron_result > argmax_val) begin
                  argmax_idx <= neuron_sel;
                  argmax_val <= neuron_result;
               end
               if (neuron_sel == LAST) begin
                  layer_done <= 1'b1;
                  state      <= DONE;
               end else begin
                  neuron_sel   <= neuron_sel + 1'b1;
                  neuron_start <= 1'b1;
                  state        <= ISSUE;
               end
            end
            DONE: begin
               layer_busy <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
